// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous 16-bit SRAM with a WAIT_CYCLES-wide strobe.
// Optional macro SRAM_ARB_FIXED_PRIORITY_EN: port 0 always wins ties.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2  // strobe width in clk cycles, legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [18:0] p0_adr,
  input  logic [15:0] p0_wdat,
  output logic [15:0] p0_rdat,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [18:0] p1_adr,
  input  logic [15:0] p1_wdat,
  output logic [15:0] p1_rdat,
  output logic        p1_ack,
  output logic [18:0] sram_adr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_doe,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_grant;
  logic [18:0] r_adr;
  logic [15:0] r_dout;
  logic [15:0] r_rdat0, r_rdat1;
  logic        r_ack0, r_ack1;
  logic        r_doe, r_cs_n, r_oe_n, r_we_n;

  logic        w_any_req;
  logic        w_pick1;
  logic        w_sel_we;
  logic [18:0] w_sel_adr;
  logic [15:0] w_sel_wdat;

  assign w_any_req = p0_req | p1_req;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
  assign w_pick1 = p1_req & ~p0_req;
`else
  // On a tie, port 1 wins only if port 0 owned the previous access.
  assign w_pick1 = p1_req & (~p0_req | ~r_grant);
`endif
  assign w_sel_we   = w_pick1 ? p1_we   : p0_we;
  assign w_sel_adr  = w_pick1 ? p1_adr  : p0_adr;
  assign w_sel_wdat = w_pick1 ? p1_wdat : p0_wdat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_grant <= 1'b1;
      r_adr   <= '0;
      r_dout  <= '0;
      r_rdat0 <= '0;
      r_rdat1 <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_doe   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere here; acks default low and are raised only on the DONE entry edge.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= ACCESS;
            r_grant <= w_pick1;
            r_we    <= w_sel_we;
            r_adr   <= w_sel_adr;
            r_dout  <= w_sel_wdat;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_cs_n  <= 1'b0;
            r_oe_n  <= w_sel_we;
            r_we_n  <= ~w_sel_we;
            r_doe   <= w_sel_we;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd1) begin
            r_state <= DONE;
            r_cs_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            if (!r_we) begin
              if (r_grant) r_rdat1 <= sram_din;
              else         r_rdat0 <= sram_din;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // Write data stays driven through DONE for one cycle of hold.
          r_state <= IDLE;
          r_doe   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_adr  = r_adr;
  assign sram_dout = r_dout;
  assign sram_doe  = r_doe;
  assign sram_cs_n = r_cs_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign p0_rdat   = r_rdat0;
  assign p1_rdat   = r_rdat1;
  assign p0_ack    = r_ack0;
  assign p1_ack    = r_ack1;
  assign busy      = (r_state != IDLE);
  assign grant     = r_grant;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM strobe width in clk cycles; legal range 1..15.
REQ-002 Clock is clk, one clock; reset is rst, synchronous, active-high.
REQ-003 clk  in  1  100 MHz system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 pN_req  in  1  access request, N in {0,1}; held high until pN_ack.
REQ-006 pN_we  in  1  1 = write, 0 = read; stable while pN_req high.
REQ-007 pN_adr  in  19  word address; stable while pN_req high.
REQ-008 pN_wdat  in  16  write data; stable while pN_req high.
REQ-009 pN_rdat  out  16  read data; valid in the pN_ack cycle, held until the next read completion on port N.
REQ-010 pN_ack  out  1  one-cycle completion pulse.
REQ-011 sram_adr  out  19  SRAM address.
REQ-012 sram_dout  out  16  SRAM write data.
REQ-013 sram_din  in  16  SRAM read data.
REQ-014 sram_doe  out  1  data-bus drive enable for the top-level tristate.
REQ-015 sram_cs_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 grant  out  1  index of the port owning the current or last access.

Function
REQ-018 States SHALL be IDLE, ACCESS and DONE.
REQ-019 In IDLE with any pN_req high, the arbiter SHALL select a winner, register its adr, wdat and we, and enter ACCESS on the next edge.
REQ-020 Round-robin: when both requests are high, the port not granted last SHALL win; when one request is high, that port SHALL win.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles, with sram_cs_n=0 and sram_adr equal to the registered address.
REQ-022 A read SHALL drive sram_oe_n=0, sram_we_n=1 and sram_doe=0.
REQ-023 A write SHALL drive sram_we_n=0, sram_oe_n=1, sram_doe=1 and sram_dout equal to the registered wdat.
REQ-024 A read SHALL capture sram_din into pN_rdat on the last ACCESS cycle.
REQ-025 In DONE, all strobes SHALL be 1 and pN_ack=1 for the granted port only.
REQ-026 On a write, DONE SHALL keep sram_doe=1 and sram_dout stable, giving one cycle of data hold; sram_doe SHALL be 0 in IDLE.
REQ-027 DONE SHALL always advance to IDLE, so the minimum spacing between accesses is one IDLE cycle.
REQ-028 Latency: request sampled in IDLE at cycle t SHALL produce ack at t+WAIT_CYCLES+1.
REQ-029 Request changes during ACCESS or DONE SHALL have no effect on the access in progress.
REQ-030 A pN_req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-031 At most one pN_ack SHALL be high in any cycle, and never outside DONE.
REQ-032 The WAIT_CYCLES counter SHALL be 4 bits wide; it reloads on entry to ACCESS and never wraps.

Reset
REQ-033 rst high SHALL force state IDLE and busy=0 on the next edge, aborting any access in flight with no ack.
REQ-034 rst SHALL force sram_cs_n=1, sram_oe_n=1, sram_we_n=1 and sram_doe=0.
REQ-035 rst SHALL force sram_adr=0, sram_dout=0, p0_rdat=0, p1_rdat=0, p0_ack=0, p1_ack=0 and grant=1, so port 0 wins the first tie.

Configuration
REQ-036 With macro SRAM_ARB_FIXED_PRIORITY_EN defined, port 0 SHALL always win ties and grant SHALL be used only for ack steering.
REQ-037 With SRAM_ARB_FIXED_PRIORITY_EN undefined, arbitration SHALL be round-robin per REQ-020.

Verification
REQ-038 Reset, then p0 write adr=0x00010, wdat=0xBEEF -> sram_we_n low 2 cycles, sram_cs_n low 2 cycles, p0_ack at t+3, sram_doe low in the following IDLE.
REQ-039 p1 read adr=0x00010 with the SRAM model holding 0xBEEF -> sram_oe_n low 2 cycles, p1_rdat=0xBEEF with p1_ack at t+3.
REQ-040 p0_req and p1_req held high together, starting from reset -> grants alternate p0, p1, p0, p1; each ack is followed by one IDLE cycle.
REQ-041 Same stimulus as REQ-040 with SRAM_ARB_FIXED_PRIORITY_EN defined -> every access granted to p0 and p1_ack never asserted.
REQ-042 rst asserted in the second ACCESS cycle of a write -> next cycle all strobes 1, sram_doe=0, no ack, busy=0.
REQ-043 WAIT_CYCLES=1 read -> sram_oe_n low 1 cycle, ack at t+2.
